// File: rtl/alu_mul_seq.sv
// alu_mul_seq: sequential unsigned 16x16->32 shift-add multiplier.
// The block shares the execute-stage ALU with the pipeline. While it is idle,
// the pipeline's ALU controls pass straight through. While a multiply runs,
// the block drives the ALU with add operations and stalls the pipeline.
module alu_mul_seq #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] mul_a,
    input  logic [WIDTH-1:0] mul_b,
    input  logic [WIDTH-1:0] pipe_A,
    input  logic [WIDTH-1:0] pipe_B,
    input  logic             pipe_Cin,
    input  logic             pipe_invA,
    input  logic             pipe_invB,
    input  logic             pipe_sign,
    input  logic [3:0]       pipe_Op,
    output logic [WIDTH-1:0] alu_A,
    output logic [WIDTH-1:0] alu_B,
    output logic             alu_Cin,
    output logic             alu_invA,
    output logic             alu_invB,
    output logic             alu_sign,
    output logic [3:0]       alu_Op,
    input  logic [WIDTH-1:0] alu_Out,
    input  logic             alu_Ofl,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] prod_hi,
    output logic [WIDTH-1:0] prod_lo
);

    localparam logic [3:0]       OP_ADD   = 4'b0100;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_ADD, S_SHIFT, S_DONE} state_t;

    // One bundle per ALU requester, so the mux below is a single select.
    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic             inva;
        logic             invb;
        logic             sign;
        logic [3:0]       op;
    } alu_ctl_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] mc, hi, lo;
    logic             c;
    logic [CNT_W-1:0] cnt;
    logic             busy;
    logic             accept;
    alu_ctl_t         pipe_ctl, mul_ctl, alu_ctl;

    assign busy   = (state == S_ADD) || (state == S_SHIFT);
    assign accept = start && !busy;

    assign pipe_ctl = '{a: pipe_A, b: pipe_B, cin: pipe_Cin, inva: pipe_invA,
                        invb: pipe_invB, sign: pipe_sign, op: pipe_Op};
    // Unsigned add with no carry-in, so alu_Ofl is the carry-out of hi+mc.
    assign mul_ctl  = '{a: hi, b: mc, cin: 1'b0, inva: 1'b0,
                        invb: 1'b0, sign: 1'b0, op: OP_ADD};
    assign alu_ctl  = busy ? mul_ctl : pipe_ctl;

    assign alu_A    = alu_ctl.a;
    assign alu_B    = alu_ctl.b;
    assign alu_Cin  = alu_ctl.cin;
    assign alu_invA = alu_ctl.inva;
    assign alu_invB = alu_ctl.invb;
    assign alu_sign = alu_ctl.sign;
    assign alu_Op   = alu_ctl.op;

    assign stall    = busy;
    assign done     = (state == S_DONE);
    assign prod_hi  = hi;
    assign prod_lo  = lo;

    // State register; reset aborts any multiply in flight.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next state: a start is taken only from IDLE or DONE; the multiplier
    // LSB decides whether each bit costs an ADD before its SHIFT.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = mul_b[0] ? S_ADD : S_SHIFT;
            S_DONE:  state_nxt = start ? (mul_b[0] ? S_ADD : S_SHIFT) : S_IDLE;
            S_ADD:   state_nxt = S_SHIFT;
            S_SHIFT: begin
                if (cnt == CNT_LAST) state_nxt = S_DONE;
                else                 state_nxt = lo[1] ? S_ADD : S_SHIFT;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: load operands, capture ALU sum and carry, then shift {c,hi,lo}.
    always_ff @(posedge clk) begin
        if (rst) begin
            mc  <= '0;
            hi  <= '0;
            lo  <= '0;
            c   <= 1'b0;
            cnt <= '0;
        end else begin
            case (state)
                S_ADD: begin
                    hi <= alu_Out;
                    c  <= alu_Ofl;
                end
                S_SHIFT: begin
                    {c, hi, lo} <= {1'b0, c, hi, lo[WIDTH-1:1]};
                    cnt         <= cnt + 1'b1;
                end
                default: begin
                    if (accept) begin
                        mc  <= mul_a;
                        hi  <= '0;
                        lo  <= mul_b;
                        c   <= 1'b0;
                        cnt <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: a behavioural ALU feeds the DUT, and products and
// latencies are predicted from plain arithmetic (a*b, 16+popcount(b)).
module tb_alu_mul_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] mul_a = '0, mul_b = '0;
    logic [15:0] pipe_A = '0, pipe_B = '0;
    logic        pipe_Cin = 1'b0, pipe_invA = 1'b0, pipe_invB = 1'b0, pipe_sign = 1'b0;
    logic [3:0]  pipe_Op = '0;
    logic [15:0] alu_A, alu_B, alu_Out;
    logic        alu_Cin, alu_invA, alu_invB, alu_sign, alu_Ofl;
    logic [3:0]  alu_Op;
    logic        stall, done;
    logic [15:0] prod_hi, prod_lo;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_mul_seq dut (
        .clk(clk), .rst(rst), .start(start), .mul_a(mul_a), .mul_b(mul_b),
        .pipe_A(pipe_A), .pipe_B(pipe_B), .pipe_Cin(pipe_Cin),
        .pipe_invA(pipe_invA), .pipe_invB(pipe_invB), .pipe_sign(pipe_sign),
        .pipe_Op(pipe_Op), .alu_A(alu_A), .alu_B(alu_B), .alu_Cin(alu_Cin),
        .alu_invA(alu_invA), .alu_invB(alu_invB), .alu_sign(alu_sign),
        .alu_Op(alu_Op), .alu_Out(alu_Out), .alu_Ofl(alu_Ofl),
        .stall(stall), .done(done), .prod_hi(prod_hi), .prod_lo(prod_lo)
    );

    // Behavioural ALU: op 0100 is add (carry-out on Ofl); other ops give xor.
    logic [15:0] opa, opb;
    logic [16:0] sum;
    always_comb begin
        opa     = alu_invA ? ~alu_A : alu_A;
        opb     = alu_invB ? ~alu_B : alu_B;
        sum     = {1'b0, opa} + {1'b0, opb} + {16'b0, alu_Cin};
        alu_Out = (alu_Op == 4'b0100) ? sum[15:0] : (opa ^ opb);
        alu_Ofl = sum[16];
    end

    // Drives one multiply from a negedge and returns at the negedge where
    // done is seen. lat counts edges from the start edge to DONE entry.
    // An optional one-cycle start poke with other operands mid-run.
    task automatic run_mul(input logic [15:0] a, input logic [15:0] b,
                           input int poke_cyc, input logic [15:0] pa,
                           input logic [15:0] pb, output int lat,
                           output int stl, output bit op_ok, output bit to);
        lat = 0; stl = 0; op_ok = 1'b1; to = 1'b1;
        mul_a = a; mul_b = b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                lat = n - 1;
                to  = 1'b0;
                break;
            end
            if (stall) begin
                stl++;
                if (alu_Op !== 4'b0100 || alu_Cin !== 1'b0 || alu_invA !== 1'b0 ||
                    alu_invB !== 1'b0 || alu_sign !== 1'b0 || alu_B !== a)
                    op_ok = 1'b0;
            end
            if (n == poke_cyc) begin
                start = 1'b1; mul_a = pa; mul_b = pb;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (stall !== 1'b0 || done !== 1'b0 || {prod_hi, prod_lo} !== 32'h0) begin
            errors++;
            $display("FAIL reset: stall=%b done=%b prod=%h want 0 0 00000000",
                     stall, done, {prod_hi, prod_lo});
        end
    endtask

    task automatic test_passthrough();
        for (int i = 0; i < 4; i++) begin
            if (i == 0) begin
                pipe_Op = 4'b0101; pipe_A = 16'h1234; pipe_B = 16'h0034;
                {pipe_Cin, pipe_invA, pipe_invB, pipe_sign} = 4'b0000;
            end else begin
                pipe_Op = 4'($urandom); pipe_A = 16'($urandom); pipe_B = 16'($urandom);
                {pipe_Cin, pipe_invA, pipe_invB, pipe_sign} = 4'($urandom);
            end
            #1;
            checks++;
            if ({alu_A, alu_B, alu_Cin, alu_invA, alu_invB, alu_sign, alu_Op} !==
                {pipe_A, pipe_B, pipe_Cin, pipe_invA, pipe_invB, pipe_sign, pipe_Op}) begin
                errors++;
                $display("FAIL passthrough[%0d]: alu A=%h B=%h op=%b want A=%h B=%h op=%b",
                         i, alu_A, alu_B, alu_Op, pipe_A, pipe_B, pipe_Op);
            end
            @(negedge clk);
        end
        checks++;
        if (stall !== 1'b0 || done !== 1'b0 || {prod_hi, prod_lo} !== 32'h0) begin
            errors++;
            $display("FAIL idle_outputs: stall=%b done=%b prod=%h want 0 0 0",
                     stall, done, {prod_hi, prod_lo});
        end
    endtask

    // Products and latency against a*b and 16+popcount(b).
    task automatic test_multiply(input int n_rand);
        logic [15:0] ta[$];
        logic [15:0] tb[$];
        int lat, stl;
        bit ok, to;
        ta = '{16'd3, 16'hFFFF, 16'hABCD, 16'h0000, 16'h8000, 16'h0001};
        tb = '{16'd5, 16'hFFFF, 16'h0000, 16'h8001, 16'h8000, 16'hFFFF};
        for (int i = 0; i < n_rand; i++) begin
            ta.push_back(16'($urandom));
            tb.push_back(16'($urandom));
        end
        for (int i = 0; i < ta.size(); i++) begin
            run_mul(ta[i], tb[i], -1, 16'h0, 16'h0, lat, stl, ok, to);
            checks++;
            if (to) begin
                errors++;
                $display("FAIL mul_timeout[%0d]: no done for %h*%h", i, ta[i], tb[i]);
                continue;
            end
            if ({prod_hi, prod_lo} !== 32'(ta[i]) * 32'(tb[i])) begin
                errors++;
                $display("FAIL mul_prod[%0d]: %h*%h got %h want %h", i, ta[i], tb[i],
                         {prod_hi, prod_lo}, 32'(ta[i]) * 32'(tb[i]));
            end
            checks++;
            if (lat != 16 + $countones(tb[i]) || stl != lat) begin
                errors++;
                $display("FAIL mul_latency[%0d]: b=%h lat=%0d stall=%0d want %0d",
                         i, tb[i], lat, stl, 16 + $countones(tb[i]));
            end
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL mul_alu_ctl[%0d]: ALU not driven as add hi+mc", i);
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || {prod_hi, prod_lo} !== 32'(ta[i]) * 32'(tb[i])) begin
                errors++;
                $display("FAIL mul_after_done[%0d]: done=%b prod=%h want 0 %h", i, done,
                         {prod_hi, prod_lo}, 32'(ta[i]) * 32'(tb[i]));
            end
        end
    endtask

    task automatic test_ignore_start();
        int lat, stl;
        bit ok, to;
        run_mul(16'd3, 16'd5, 5, 16'd7, 16'd9, lat, stl, ok, to);
        checks++;
        if (to || {prod_hi, prod_lo} !== 32'h0000000F || lat != 18) begin
            errors++;
            $display("FAIL ignore_start: to=%b prod=%h lat=%0d want 0000000f 18",
                     to, {prod_hi, prod_lo}, lat);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lat, stl;
        bit ok, to;
        run_mul(16'd3, 16'd5, -1, 16'h0, 16'h0, lat, stl, ok, to);
        pipe_A = 16'h5A5A; pipe_Op = 4'b0010;
        #1;
        checks++;
        if (to || alu_A !== 16'h5A5A || alu_Op !== 4'b0010) begin
            errors++;
            $display("FAIL done_passthrough: alu_A=%h op=%b want 5a5a 0010", alu_A, alu_Op);
        end
        // Start held in the DONE cycle: accepted without an IDLE gap.
        run_mul(16'h0100, 16'h0100, -1, 16'h0, 16'h0, lat, stl, ok, to);
        checks++;
        if (to || {prod_hi, prod_lo} !== 32'h00010000 || lat != 17 || stl != 17) begin
            errors++;
            $display("FAIL back_to_back: to=%b prod=%h lat=%0d stall=%0d want 00010000 17 17",
                     to, {prod_hi, prod_lo}, lat, stl);
        end
        @(negedge clk);
    endtask

    task automatic test_abort();
        int lat, stl;
        bit ok, to, seen;
        mul_a = 16'h1234; mul_b = 16'h5678; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (stall !== 1'b0 || done !== 1'b0 || {prod_hi, prod_lo} !== 32'h0) begin
            errors++;
            $display("FAIL abort_state: stall=%b done=%b prod=%h want 0 0 0",
                     stall, done, {prod_hi, prod_lo});
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done || stall) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL abort_quiet: done/stall seen after reset, want none");
        end
        run_mul(16'h1234, 16'h5678, -1, 16'h0, 16'h0, lat, stl, ok, to);
        checks++;
        if (to || {prod_hi, prod_lo} !== 32'h06260060) begin
            errors++;
            $display("FAIL abort_rerun: to=%b prod=%h want 06260060", to, {prod_hi, prod_lo});
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_multiply(20);
        test_ignore_start();
        test_back_to_back();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
- Multi-cycle unsigned 16x16->32 shift-add multiplier sequencer.
- Time-shares the single 16-bit ALU between the execute-stage pipeline and the multiplier.
- When idle, pipeline ALU controls pass straight through.
- When a multiply is running, the block takes over the ALU, issues add operations, stalls the pipeline and returns a 32-bit product.

Parameters:
WIDTH, 16, operand width; fixed at 16 to match the ALU datapath
CNT_W, 4, iteration counter width (log2 WIDTH)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  multiply request; sampled in IDLE or DONE only
mul_a  input  16  multiplicand (unsigned), sampled with start
mul_b  input  16  multiplier (unsigned), sampled with start
pipe_A, pipe_B  input  16 each  pipeline ALU operands
pipe_Cin, pipe_invA, pipe_invB, pipe_sign  input  1 each  pipeline ALU controls
pipe_Op  input  4  pipeline ALU opcode
alu_A, alu_B  output  16 each  to ALU
alu_Cin, alu_invA, alu_invB, alu_sign  output  1 each  to ALU
alu_Op  output  4  to ALU
alu_Out  input  16  ALU result
alu_Ofl  input  1  ALU overflow; equals carry-out for unsigned add
stall  output  1  pipeline must hold; high in ADD/SHIFT
done  output  1  one-cycle product-valid pulse
prod_hi  output  16  product bits 31:16
prod_lo  output  16  product bits 15:0

Behaviour:
- Internal registers:
  - mc[15:0]: multiplicand.
  - hi[15:0], lo[15:0]: accumulator and multiplier.
  - c: carry bit.
  - cnt[3:0]: iteration counter.
  - state: IDLE, ADD, SHIFT, DONE.
- Reset:
  - state=IDLE; mc, hi, lo, c, cnt = 0.
  - done=0, stall=0, prod_hi=prod_lo=0.
  - rst mid-operation aborts immediately; no done pulse.
- ALU mux:
  - IDLE/DONE: every alu_* output equals its pipe_* input, combinationally.
  - ADD/SHIFT: alu_A=hi, alu_B=mc, alu_Cin=0, alu_Op=4'b0100 (add), alu_invA=alu_invB=0, alu_sign=0 (unsigned, so alu_Ofl=carry-out).
- IDLE or DONE, start=1:
  - mc<=mul_a, hi<=0, c<=0, lo<=mul_b, cnt<=0.
  - next state = ADD if mul_b[0] else SHIFT.
  - IDLE, start=0: stay in IDLE.
  - DONE, start=0: go to IDLE.
- ADD: hi<=alu_Out, c<=alu_Ofl; next state SHIFT.
- SHIFT:
  - 33-bit logical right shift, {c,hi,lo}<={1'b0,c,hi,lo[15:1]}; c cleared.
  - cnt<=cnt+1.
  - If cnt==15: next DONE.
  - Otherwise: next ADD if lo[1]==1 (the new lo[0]), else SHIFT.
- Latency:
  - If start is sampled at clock edge E0, state DONE begins exactly 16+popcount(mul_b) edges later.
  - Range: 16 (mul_b=0) to 32 (mul_b=0xFFFF).
- Outputs:
  - done=1 only in DONE (exactly one cycle).
  - stall=1 only in ADD and SHIFT.
  - {prod_hi,prod_lo}={hi,lo}; valid in DONE; held until the next accepted start.
- start in ADD/SHIFT is ignored (no queuing); the pipeline must re-assert it.
- start in DONE is accepted: back-to-back multiply, no IDLE cycle, done drops the next cycle.
- No signed mode; the pipeline handles signs externally.
- cnt wraps 15->0 only on the final SHIFT; it is reloaded on start.

Test Plan:
- rst, then idle with pipe_Op=4'b0101, pipe_A=0x1234, pipe_B=0x0034 -> alu_* mirror pipe_* same cycle; stall=0, done=0, prod=0.
- start, mul_a=3, mul_b=5 -> stall high 18 cycles; alu_Op=0100 throughout; done pulses on cycle 18 after start edge; prod_hi=0x0000, prod_lo=0x000F.
- mul_a=0xFFFF, mul_b=0xFFFF -> done after 32 cycles; prod_hi=0xFFFE, prod_lo=0x0001; carry capture exercised on every ADD.
- mul_a=0xABCD, mul_b=0 -> no ADD states, done after 16 cycles; product 0x00000000. Then mul_a=0, mul_b=0x8001 -> done after 18 cycles; product 0.
- start re-asserted mid-multiply with different operands -> ignored; original product 3*5=0x000F. start held high in DONE with mul_a=0x0100, mul_b=0x0100 -> accepted, done after 17 further cycles; product 0x00010000.
- rst asserted 7 cycles into 0x1234*0x5678 -> next cycle state IDLE, stall=0, done never pulses, prod=0. Rerun to completion -> 0x06260060.
